// File: rtl/clock_div_pkg.sv
// Shared definitions for the ref_clock divider sequencer: state encoding,
// parameter defaults and small state-decode helpers.
package clock_div_pkg;

    localparam int DIVIDER_BW_DEF  = 24;
    localparam int GAP_CYCLES_DEF  = 4;
    localparam int DEFAULT_DIV_DEF = 2;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_GAP    = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    // Divider enable is high in every state where the divided clock is toggling.
    function automatic logic state_enable(input state_t s);
        logic en;
        case (s)
            ST_RUN, ST_DRAIN, ST_SETTLE: en = 1'b1;
            default:                     en = 1'b0;
        endcase
        return en;
    endfunction

    // Busy covers the whole reconfiguration sequence.
    function automatic logic state_busy(input state_t s);
        logic bz;
        case (s)
            ST_DRAIN, ST_GAP, ST_SETTLE: bz = 1'b1;
            default:                     bz = 1'b0;
        endcase
        return bz;
    endfunction

endpackage

// File: rtl/clock_div_phase_tracker.sv
// Mirror of the divider's internal counter. Runs while enable is high, holds
// while low, and flags the last cycle of a divided period (the boundary).
// A divider of 0 or 1 is a bypass, so every cycle is a boundary.
module clock_div_phase_tracker
    import clock_div_pkg::*;
#(
    parameter int DIVIDER_BW = DIVIDER_BW_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic [DIVIDER_BW-1:0] i_divider,
    output logic                  o_boundary
);

    localparam logic [DIVIDER_BW-1:0] ZERO = {DIVIDER_BW{1'b0}};
    localparam logic [DIVIDER_BW-1:0] ONE  = {{(DIVIDER_BW-1){1'b0}}, 1'b1};

    logic [DIVIDER_BW-1:0] r_phase;
    logic                  w_at_last;
    logic                  w_bypass;

    assign w_at_last  = (r_phase == (i_divider - ONE));
    assign w_bypass   = (i_divider <= ONE);
    assign o_boundary = (i_enable & w_at_last) | w_bypass;

    // Phase counter: wraps at divider-1 while enabled, frozen otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= ZERO;
        end else if (i_enable) begin
            if (w_at_last) begin
                r_phase <= ZERO;
            end else begin
                r_phase <= r_phase + ONE;
            end
        end else begin
            r_phase <= r_phase;
        end
    end

endmodule

// File: rtl/clock_div_ctrl.sv
// Sequencer owning enable_clock_gen/divider_value of the ref_clock divider.
// Run/stop and divider-change requests take effect only at a period boundary:
// drain to the boundary, drop enable, load the new value, hold a gap, restart,
// and report lock after one full new period. No runt pulses are produced.
module clock_div_ctrl
    import clock_div_pkg::*;
#(
    parameter int DIVIDER_BW  = DIVIDER_BW_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                  ref_clock,
    input  logic                  reset_n,
    input  logic                  clk_en_req,
    input  logic                  cfg_req,
    input  logic [DIVIDER_BW-1:0] cfg_div,
    output logic                  cfg_ack,
    output logic                  cfg_err,
    output logic                  enable_clock_gen,
    output logic [DIVIDER_BW-1:0] divider_value,
    output logic                  busy,
    output logic                  locked
);

    localparam logic [DIVIDER_BW-1:0] ZERO     = {DIVIDER_BW{1'b0}};
    localparam logic [DIVIDER_BW-1:0] ONE      = {{(DIVIDER_BW-1){1'b0}}, 1'b1};
    localparam logic [DIVIDER_BW-1:0] DIV_RST  = DIVIDER_BW'(DEFAULT_DIV);
    localparam logic [DIVIDER_BW-1:0] GAP_LAST = DIVIDER_BW'(GAP_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_enable;
    logic                  r_busy;
    logic                  r_locked;
    logic                  r_cfg_ack;
    logic                  r_cfg_err;
    logic [DIVIDER_BW-1:0] r_divider;
    logic [DIVIDER_BW-1:0] r_pend_div;
    logic                  r_pend_vld;
    logic [DIVIDER_BW-1:0] r_gap_cnt;

    logic w_boundary;
    logic w_cfg_take;
    logic w_cfg_ok;
    logic w_cfg_bad;
    logic w_gap_done;
    logic w_load;

    clock_div_phase_tracker #(
        .DIVIDER_BW (DIVIDER_BW)
    ) u_phase (
        .i_clk      (ref_clock),
        .i_rst_n    (reset_n),
        .i_enable   (r_enable),
        .i_divider  (r_divider),
        .o_boundary (w_boundary)
    );

    // A request is only looked at in OFF/RUN. The ack/err guard stops a
    // request still held during its own ack/err cycle from being taken twice.
    assign w_cfg_take = cfg_req & ((r_state == ST_OFF) | (r_state == ST_RUN))
                        & ~r_cfg_ack & ~r_cfg_err;
    assign w_cfg_ok   = w_cfg_take & (cfg_div != ZERO);
    assign w_cfg_bad  = w_cfg_take & (cfg_div == ZERO);
    assign w_gap_done = (r_gap_cnt == GAP_LAST);
    // Load one cycle into the gap, so the value never moves on the edge
    // that drops enable.
    assign w_load     = (r_state == ST_GAP) & (r_gap_cnt == ZERO) & r_pend_vld;

    assign cfg_ack          = r_cfg_ack;
    assign cfg_err          = r_cfg_err;
    assign enable_clock_gen = r_enable;
    assign divider_value    = r_divider;
    assign busy             = r_busy;
    assign locked           = r_locked;

    // Next-state decode for the sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF: begin
                if (w_cfg_ok) begin
                    w_state_nxt = ST_GAP;
                end else if (clk_en_req) begin
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_state_nxt = ST_OFF;
                end
            end
            ST_RUN: begin
                if (w_cfg_ok || !clk_en_req) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_boundary) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    if (clk_en_req) begin
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_state_nxt = ST_OFF;
                    end
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_SETTLE: begin
                if (!clk_en_req) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_boundary) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase
    end

    // State register plus outputs decoded from the next state, so every
    // output is a flop that lines up with the state it belongs to.
    always_ff @(posedge ref_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_OFF;
            r_enable  <= 1'b0;
            r_busy    <= 1'b0;
            r_locked  <= 1'b0;
            r_cfg_ack <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_enable  <= state_enable(w_state_nxt);
            r_busy    <= state_busy(w_state_nxt);
            r_locked  <= (w_state_nxt == ST_RUN);
            r_cfg_ack <= w_cfg_ok;
            r_cfg_err <= w_cfg_bad;
        end
    end

    // Pending divider capture on accept and divider load during the gap.
    always_ff @(posedge ref_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_div <= ZERO;
            r_pend_vld <= 1'b0;
            r_divider  <= DIV_RST;
        end else if (w_cfg_ok) begin
            r_pend_div <= cfg_div;
            r_pend_vld <= 1'b1;
        end else if (w_load) begin
            r_pend_vld <= 1'b0;
            r_divider  <= r_pend_div;
        end else begin
            r_pend_vld <= r_pend_vld;
        end
    end

    // Gap length counter: counts only inside GAP, cleared everywhere else.
    always_ff @(posedge ref_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gap_cnt <= ZERO;
        end else if ((r_state == ST_GAP) && !w_gap_done) begin
            r_gap_cnt <= r_gap_cnt + ONE;
        end else begin
            r_gap_cnt <= ZERO;
        end
    end

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl. The stimulus pushes every expected output
// change (cycle stamp + output snapshot) into a queue; a negedge monitor pops
// and compares each time the DUT outputs change.
module tb_clock_div_ctrl;

    localparam int BW = 24;

    logic          ref_clock;
    logic          reset_n;
    logic          clk_en_req;
    logic          cfg_req;
    logic [BW-1:0] cfg_div;
    logic          cfg_ack;
    logic          cfg_err;
    logic          enable_clock_gen;
    logic [BW-1:0] divider_value;
    logic          busy;
    logic          locked;

    clock_div_ctrl #(
        .DIVIDER_BW  (BW),
        .GAP_CYCLES  (4),
        .DEFAULT_DIV (2)
    ) dut (
        .ref_clock        (ref_clock),
        .reset_n          (reset_n),
        .clk_en_req       (clk_en_req),
        .cfg_req          (cfg_req),
        .cfg_div          (cfg_div),
        .cfg_ack          (cfg_ack),
        .cfg_err          (cfg_err),
        .enable_clock_gen (enable_clock_gen),
        .divider_value    (divider_value),
        .busy             (busy),
        .locked           (locked)
    );

    // snapshot = {enable, divider, busy, locked, ack, err}
    typedef struct {
        int          t;
        logic [28:0] v;
    } ev_t;

    localparam logic [28:0] RST_SNAP = {1'b0, 24'd2, 4'b0000};

    ev_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [28:0] prev  = RST_SNAP;
    logic [28:0] mon_cur;
    ev_t         mon_e;

    initial ref_clock = 1'b0;
    always #50 ref_clock = ~ref_clock;

    always @(posedge ref_clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int t, input logic en, input int dv, input logic bz,
                        input logic lk, input logic ak, input logic er);
        ev_t e;
        e.t = t;
        e.v = {en, 24'(dv), bz, lk, ak, er};
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge ref_clock);
            #1;
        end
    endtask

    task automatic drain_q(input int lim);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < lim) begin
            @(posedge ref_clock);
            #1;
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d events still outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every output change must match the next expected event.
    always @(negedge ref_clock) begin
        mon_cur = {enable_clock_gen, divider_value, busy, locked, cfg_ack, cfg_err};
        if (!reset_n) begin
            prev = RST_SNAP;
        end else if (mon_cur != prev) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: actual %0h at cycle %0d, required no change", mon_cur, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_cycle", 64'(cyc), 64'(mon_e.t));
                chk("event_value", 64'(mon_cur), 64'(mon_e.v));
            end
            prev = mon_cur;
        end
    end

    initial begin
        int c;
        int e;
        reset_n    = 1'b0;
        clk_en_req = 1'b0;
        cfg_req    = 1'b0;
        cfg_div    = 24'd0;
        #60;
        chk("rst_enable",  64'(enable_clock_gen), 64'd0);
        chk("rst_divider", 64'(divider_value),    64'd2);
        chk("rst_busy",    64'(busy),             64'd0);
        chk("rst_locked",  64'(locked),           64'd0);
        chk("rst_ack_err", 64'({cfg_ack, cfg_err}), 64'd0);
        repeat (2) @(posedge ref_clock);
        #1;
        reset_n = 1'b1;

        // Start from OFF, div 2: two SETTLE cycles, then RUN/locked.
        c = cyc + 2;
        wait_to(c);
        clk_en_req = 1'b1;
        push(c + 1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 3, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        e = c + 3;

        // cfg_div = 0 in RUN: err pulse only, nothing else moves.
        c = e + 2;
        wait_to(c);
        cfg_req = 1'b1;
        cfg_div = 24'd0;
        push(c + 1, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b1);
        push(c + 2, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_to(c + 1);
        cfg_req = 1'b0;

        // cfg 4 together with clk_en_req fall, phase 0 of div 2: one drain, load, gap, OFF.
        c = e + 10;
        wait_to(c);
        cfg_req    = 1'b1;
        cfg_div    = 24'd4;
        clk_en_req = 1'b0;
        push(c + 1, 1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b0);
        push(c + 2, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 3, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 6, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_to(c + 1);
        cfg_req = 1'b0;

        // OFF -> SETTLE with div 4: four settle cycles.
        c = c + 8;
        wait_to(c);
        clk_en_req = 1'b1;
        push(c + 1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 5, 1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b0);
        e = c + 5;

        // RUN div 4, cfg 6 at phase 1: drain 2, gap 4, settle 6.
        c = e + 9;
        wait_to(c);
        cfg_req = 1'b1;
        cfg_div = 24'd6;
        push(c + 1,  1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        push(c + 2,  1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 3,  1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 4,  1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 7,  1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 13, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_to(c + 1);
        cfg_req = 1'b0;
        e = c + 13;

        // cfg 3 at phase 0 of div 6, then cfg 1 raised and held through GAP/SETTLE.
        c = e + 6;
        wait_to(c);
        cfg_req = 1'b1;
        cfg_div = 24'd3;
        push(c + 1,  1'b1, 6, 1'b1, 1'b0, 1'b1, 1'b0);
        push(c + 2,  1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 6,  1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 7,  1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 10, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 13, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0);
        push(c + 14, 1'b1, 3, 1'b1, 1'b0, 1'b1, 1'b0);
        push(c + 15, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 16, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 17, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 20, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 21, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_to(c + 1);
        cfg_req = 1'b0;
        wait_to(c + 7);
        cfg_req = 1'b1;
        cfg_div = 24'd1;
        wait_to(c + 14);
        cfg_req = 1'b0;
        e = c + 21;

        // Bypass (div 1) stop: one DRAIN cycle, gap 4, OFF.
        c = e + 3;
        wait_to(c);
        clk_en_req = 1'b0;
        push(c + 1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 2, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 6, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Restart in bypass, then move to div 5.
        c = c + 8;
        wait_to(c);
        clk_en_req = 1'b1;
        push(c + 1,  1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 2,  1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_to(c + 4);
        cfg_req = 1'b1;
        cfg_div = 24'd5;
        push(c + 5,  1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0);
        push(c + 6,  1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 7,  1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 10, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 15, 1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_to(c + 5);
        cfg_req = 1'b0;
        e = c + 15;

        // cfg 7 accepted, reset asserted mid-DRAIN: pending must be dropped.
        c = e + 5;
        wait_to(c);
        cfg_req = 1'b1;
        cfg_div = 24'd7;
        push(c + 1, 1'b1, 5, 1'b1, 1'b0, 1'b1, 1'b0);
        push(c + 2, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_to(c + 1);
        cfg_req = 1'b0;
        wait_to(c + 3);
        #20;
        reset_n = 1'b0;
        #5;
        chk("mid_rst_enable",  64'(enable_clock_gen), 64'd0);
        chk("mid_rst_divider", 64'(divider_value),    64'd2);
        chk("mid_rst_busy",    64'(busy),             64'd0);
        chk("mid_rst_locked",  64'(locked),           64'd0);
        drain_q(4);
        repeat (2) @(posedge ref_clock);
        #1;
        reset_n = 1'b1;
        c = cyc;
        push(c + 1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 3, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0);

        // Stop again: divider must stay 2 through the gap.
        c = c + 5;
        wait_to(c);
        clk_en_req = 1'b0;
        push(c + 1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 2, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 6, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_to(c + 12);
        drain_q(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
